stream_checker: RTL and testbench

STREAM_CHECKER -- requirements
Module: stream_checker

---
 rtl/stream_checker_pkg.sv | 23 ++
 rtl/stream_checker_gap_timer.sv | 49 ++++
 rtl/stream_checker.sv | 166 ++++++++++++++++
 tb/tb_stream_checker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_checker_pkg
//  Purpose  : Shared definitions for the stream checker family: word width,
//             checker state encoding and the generator seed word used by
//             stimulus sources.
//  Revision : 1.0  initial release
// ============================================================================
package stream_checker_pkg;

    localparam int c_WORD_W = 32;

    // Seed word of the counting-pattern generator that feeds this checker.
    localparam logic [c_WORD_W-1:0] c_GEN_RESET_WORD = 32'hFAFBFCFD;

    // Checker state encoding.
    localparam int          c_ST_W     = 2;
    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_SYNC  = 2'd1;
    localparam logic [1:0]  c_ST_CHECK = 2'd2;

endpackage : stream_checker_pkg
`default_nettype wire

// File: rtl/stream_checker_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module   : stream_gap_timer
//  Purpose  : Counts idle clocks between accepted words while the checker is
//             locked and raises a sticky timeout flag once the gap reaches
//             TIMEOUT_TICKS. The counter saturates at the limit.
//  Revision : 1.0  initial release
// ============================================================================
module stream_gap_timer #(
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic restart,
    input  logic run,
    output logic timeout
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_TICKS);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               r_timeout;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign timeout   = r_timeout;

    // Gap counter with saturation; the flag latches when the count reaches the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (clear) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (restart) begin
            r_cnt <= '0;
        end else if (run && (r_cnt != c_LIMIT)) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == c_LIMIT) begin
                r_timeout <= 1'b1;
            end
        end
    end

endmodule : stream_gap_timer
`default_nettype wire

// File: rtl/stream_checker.sv
`default_nettype none
// ============================================================================
//  Module   : stream_checker
//  Purpose  : Locks onto an incrementing 32-bit word stream, counts accepted
//             words and mismatches, records the first mismatch, forces a
//             resync after RESYNC_ERRS consecutive bad words and flags
//             inter-word gaps that exceed TIMEOUT_TICKS.
//  Revision : 1.0  initial release
// ============================================================================
module stream_checker
    import stream_checker_pkg::*;
#(
    parameter int RESYNC_ERRS   = 4,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clear,
    input  logic [c_WORD_W-1:0] stream_32,
    input  logic                num_32_rdy,
    output logic                locked,
    output logic                err_pulse,
    output logic [15:0]         err_count,
    output logic [c_WORD_W-1:0] word_count,
    output logic [c_WORD_W-1:0] first_exp,
    output logic [c_WORD_W-1:0] first_got,
    output logic                timeout
);

    localparam int               c_BAD_W      = $clog2(RESYNC_ERRS + 1);
    localparam logic [c_BAD_W-1:0] c_RESYNC_LIM = c_BAD_W'(RESYNC_ERRS);

    logic [c_ST_W-1:0]   r_state;
    logic [c_ST_W-1:0]   w_state_nxt;
    logic                w_strobe_acc;
    logic                w_mismatch;
    logic                w_resync;

    logic [c_WORD_W-1:0] r_expected;
    logic [c_BAD_W-1:0]  r_bad_run;
    logic [c_BAD_W-1:0]  w_bad_run_inc;
    logic                r_locked;
    logic                r_err_pulse;
    logic [15:0]         r_err_count;
    logic [c_WORD_W-1:0] r_word_count;
    logic [c_WORD_W-1:0] r_first_exp;
    logic [c_WORD_W-1:0] r_first_got;
    logic                w_gap_run;

    assign w_bad_run_inc = r_bad_run + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus strobe acceptance and mismatch classification.
    always_comb begin
        w_state_nxt  = r_state;
        w_strobe_acc = 1'b0;
        w_mismatch   = 1'b0;
        w_resync     = 1'b0;
        if (clear) begin
            // A strobe coinciding with clear is dropped.
            w_state_nxt = enable ? c_ST_SYNC : c_ST_IDLE;
        end else if (!enable) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_state_nxt = c_ST_SYNC;
                end
                c_ST_SYNC: begin
                    if (num_32_rdy) begin
                        w_strobe_acc = 1'b1;
                        w_state_nxt  = c_ST_CHECK;
                    end
                end
                c_ST_CHECK: begin
                    if (num_32_rdy) begin
                        w_strobe_acc = 1'b1;
                        if (stream_32 != r_expected) begin
                            w_mismatch = 1'b1;
                            if (w_bad_run_inc == c_RESYNC_LIM) begin
                                w_resync    = 1'b1;
                                w_state_nxt = c_ST_SYNC;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // Statistics, expected-word tracking and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_expected   <= '0;
            r_bad_run    <= '0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_count  <= '0;
            r_word_count <= '0;
            r_first_exp  <= '0;
            r_first_got  <= '0;
        end else begin
            r_err_pulse <= w_mismatch;
            r_locked    <= (w_state_nxt == c_ST_CHECK);
            if (clear) begin
                r_bad_run    <= '0;
                r_err_count  <= '0;
                r_word_count <= '0;
                r_first_exp  <= '0;
                r_first_got  <= '0;
            end else if (w_strobe_acc) begin
                r_word_count <= r_word_count + 32'd1;
                // Realign on every accepted word so a single slip costs one error.
                r_expected   <= stream_32 + 32'd1;
                if (w_mismatch) begin
                    if (r_err_count != 16'hFFFF) begin
                        r_err_count <= r_err_count + 16'd1;
                    end
                    if (r_err_count == 16'd0) begin
                        r_first_exp <= r_expected;
                        r_first_got <= stream_32;
                    end
                    r_bad_run <= w_resync ? '0 : w_bad_run_inc;
                end else begin
                    r_bad_run <= '0;
                end
            end
        end
    end

    // Entry into CHECK always coincides with an accepted strobe, so the
    // strobe restart also covers the entry restart.
    assign w_gap_run = (r_state == c_ST_CHECK);

    stream_gap_timer #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .restart (w_strobe_acc),
        .run     (w_gap_run),
        .timeout (timeout)
    );

    assign locked     = r_locked;
    assign err_pulse  = r_err_pulse;
    assign err_count  = r_err_count;
    assign word_count = r_word_count;
    assign first_exp  = r_first_exp;
    assign first_got  = r_first_got;

endmodule : stream_checker
`default_nettype wire

// File: tb/tb_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_checker
//  Purpose  : Self-checking bench for stream_checker: directed scenarios and
//             randomized traffic compared every cycle with a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_checker;
    import stream_checker_pkg::*;

    localparam int c_RESYNC  = 4;
    localparam int c_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] stream_32 = '0;
    logic        num_32_rdy = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [31:0] word_count;
    logic [31:0] first_exp;
    logic [31:0] first_got;
    logic        timeout;

    int n_total = 0;
    int n_pass  = 0;
    int pulse_seen = 0;

    // Reference model: mode 0 = idle, 1 = hunting for a word, 2 = locked.
    int          m_mode;
    logic [31:0] m_next;
    int          m_bad;
    int          m_err;
    logic [31:0] m_words;
    logic [31:0] m_fexp;
    logic [31:0] m_fgot;
    bit          m_to;
    int          m_gap;
    bit          m_pulse;

    stream_checker #(
        .RESYNC_ERRS   (c_RESYNC),
        .TIMEOUT_TICKS (c_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .clear      (clear),
        .stream_32  (stream_32),
        .num_32_rdy (num_32_rdy),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .word_count (word_count),
        .first_exp  (first_exp),
        .first_got  (first_got),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_idle_tick();
        if (m_gap < c_TIMEOUT) m_gap++;
        if (m_gap >= c_TIMEOUT) m_to = 1'b1;
    endtask

    task automatic model_step(input bit r, input bit en, input bit clr, input bit rdy,
                              input logic [31:0] d);
        m_pulse = 1'b0;
        if (r) begin
            m_mode = 0; m_next = '0; m_bad = 0; m_err = 0; m_words = '0;
            m_fexp = '0; m_fgot = '0; m_to = 1'b0; m_gap = 0;
        end else if (clr) begin
            m_bad = 0; m_err = 0; m_words = '0; m_fexp = '0; m_fgot = '0;
            m_to = 1'b0; m_gap = 0;
            m_mode = en ? 1 : 0;
        end else if (!en) begin
            if (m_mode == 2) model_idle_tick();
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (rdy) begin
                m_words++; m_next = d + 32'd1; m_bad = 0; m_gap = 0; m_mode = 2;
            end
        end else begin
            if (rdy) begin
                m_words++; m_gap = 0;
                if (d == m_next) begin
                    m_bad = 0;
                end else begin
                    m_pulse = 1'b1;
                    if (m_err == 0) begin m_fexp = m_next; m_fgot = d; end
                    if (m_err < 65535) m_err++;
                    m_bad++;
                    if (m_bad == c_RESYNC) begin m_bad = 0; m_mode = 1; end
                end
                m_next = d + 32'd1;
            end else begin
                model_idle_tick();
            end
        end
    endtask

    task automatic compare_all();
        chk("locked",     {31'd0, locked},    {31'd0, (m_mode == 2)});
        chk("err_pulse",  {31'd0, err_pulse}, {31'd0, m_pulse});
        chk("err_count",  {16'd0, err_count}, 32'(m_err));
        chk("word_count", word_count,         m_words);
        chk("first_exp",  first_exp,          m_fexp);
        chk("first_got",  first_got,          m_fgot);
        chk("timeout",    {31'd0, timeout},   {31'd0, m_to});
        if (err_pulse) pulse_seen++;
    endtask

    task automatic cyc(input bit r, input bit en, input bit clr, input bit rdy,
                       input logic [31:0] d);
        @(negedge clk);
        rst = r; enable = en; clear = clr; num_32_rdy = rdy; stream_32 = d;
        @(posedge clk);
        model_step(r, en, clr, rdy, d);
        #1;
        compare_all();
    endtask

    task automatic word(input logic [31:0] d, input int gap);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, d);
        for (int i = 0; i < gap; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, $urandom);
    endtask

    task automatic do_clear();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    endtask

    logic [31:0] r_gen;

    initial begin
        // Reset with every other control asserted: reset must win.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h1234);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_wc", word_count, 32'd0);

        // Generator stream, one word every 18 clocks.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            word(c_GEN_RESET_WORD + 32'(i), 17);
            if (i == 0) chk("s1_lock_first", {31'd0, locked}, 32'd1);
        end
        chk("s1_err", {16'd0, err_count}, 32'd0);
        chk("s1_wc", word_count, 32'd10);
        chk("s1_to", {31'd0, timeout}, 32'd0);

        // Single slip in a locked stream.
        do_clear();
        pulse_seen = 0;
        word(32'd100, 2); word(32'd101, 2); word(32'd105, 2); word(32'd106, 2);
        chk("s2_pulses", 32'(pulse_seen), 32'd1);
        chk("s2_err", {16'd0, err_count}, 32'd1);
        chk("s2_fexp", first_exp, 32'd102);
        chk("s2_fgot", first_got, 32'd105);
        chk("s2_lock", {31'd0, locked}, 32'd1);

        // Wrap through 2^32.
        do_clear();
        word(32'hFFFFFFFE, 1); word(32'hFFFFFFFF, 1); word(32'h0, 1); word(32'h1, 1);
        chk("s3_err", {16'd0, err_count}, 32'd0);
        chk("s3_wc", word_count, 32'd4);

        // Four consecutive bad words drop lock; next word relocks.
        do_clear();
        word(32'd5, 1); word(32'd10, 1); word(32'd20, 1); word(32'd30, 1); word(32'd40, 1);
        chk("s4_err", {16'd0, err_count}, 32'd4);
        chk("s4_unlock", {31'd0, locked}, 32'd0);
        chk("s4_fexp", first_exp, 32'd6);
        word(32'd50, 1);
        chk("s4_relock", {31'd0, locked}, 32'd1);
        word(32'd51, 1);
        chk("s4_match", {16'd0, err_count}, 32'd4);

        // Gap timeout is sticky until clear.
        do_clear();
        word(32'd1, 70);
        chk("s5_to", {31'd0, timeout}, 32'd1);
        word(32'd2, 1); word(32'd3, 1);
        chk("s5_to_sticky", {31'd0, timeout}, 32'd1);
        do_clear();
        chk("s5_to_clr", {31'd0, timeout}, 32'd0);
        chk("s5_wc_clr", word_count, 32'd0);
        word(32'd9, 0);
        chk("s5_sync_lock", {31'd0, locked}, 32'd1);

        // Clear with strobe, then reset mid-check.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'd77);
        chk("s6_wc", word_count, 32'd0);
        word(32'd3, 1); word(32'd4, 1); word(32'd9, 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'd10);
        chk("s6_rst_lock", {31'd0, locked}, 32'd0);
        chk("s6_rst_err", {16'd0, err_count}, 32'd0);

        // Randomized traffic.
        r_gen = $urandom;
        for (int i = 0; i < 3000; i++) begin
            bit r, en, clr, rdy;
            logic [31:0] d;
            r   = ($urandom_range(0, 499) == 0);
            en  = ($urandom_range(0, 99) != 0);
            clr = ($urandom_range(0, 149) == 0);
            rdy = ($urandom_range(0, 99) < 40);
            d   = ($urandom_range(0, 99) < 88) ? r_gen : $urandom;
            if (rdy) r_gen = d + 32'd1;
            if ($urandom_range(0, 299) == 0) begin
                for (int k = 0; k < 70; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
            end
            cyc(r, en, clr, rdy, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_stream_checker
`default_nettype wire
